// File: rtl/train_pkg.sv
// Shared types for the training-pass scheduler:
// FSM state encoding, pass codes and small decode helpers.
package train_pkg;

   localparam int WDOG_W = 8;

   typedef enum logic [3:0] {
      S_IDLE,
      S_F0_GO,
      S_F0_WAIT,
      S_F1_GO,
      S_F1_WAIT,
      S_B_GO,
      S_B_WAIT,
      S_FIN,
      S_ERR
   } state_e;

   typedef enum logic [1:0] {
      PASS_NONE = 2'd0,
      PASS_F0   = 2'd1,
      PASS_F1   = 2'd2,
      PASS_B    = 2'd3
   } pass_e;

   function automatic logic is_wait(input state_e s);
      return (s == S_F0_WAIT) || (s == S_F1_WAIT) ||
             (s == S_B_WAIT);
   endfunction

   function automatic pass_e pass_of(input state_e s);
      pass_e p;
      p = PASS_NONE;
      case (s)
         S_F0_GO, S_F0_WAIT: p = PASS_F0;
         S_F1_GO, S_F1_WAIT: p = PASS_F1;
         S_B_GO,  S_B_WAIT:  p = PASS_B;
         default:            p = PASS_NONE;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/pass_watchdog.sv
// Per-pass wait counter; o_expired flags the last
// allowed wait cycle (count == TIMEOUT-1).
module pass_watchdog
   import train_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              i_clr,
   input  logic              i_en,
   output logic [WDOG_W-1:0] o_count,
   output logic              o_expired
);

   logic [WDOG_W-1:0] r_cnt;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_count   = r_cnt;
   assign o_expired = (r_cnt == WDOG_W'(TIMEOUT - 1));

endmodule

// File: rtl/train_pass_sched.sv
// Sequences f0 -> f1 -> b passes for a programmed number
// of iterations, with watchdog, abort and global enable.
module train_pass_sched
   import train_pkg::*;
#(
   parameter int ITER_W  = 4,
   parameter int TIMEOUT = 255
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              en_i,
   input  logic              start_i,
   input  logic              abort_i,
   input  logic [ITER_W-1:0] iters_i,
   input  logic              f0_done_i,
   input  logic              f1_done_i,
   input  logic              b_done_i,
   output logic              f0_start_o,
   output logic              f1_start_o,
   output logic              b_start_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o,
   output logic [1:0]        pass_o,
   output logic [ITER_W-1:0] iter_o
);

   state_e            r_state;
   state_e            w_nxt;
   logic [ITER_W-1:0] r_iters;
   logic [ITER_W-1:0] r_iter;
   logic [ITER_W-1:0] w_iter_inc;
   logic              w_in_wait;
   logic              w_wd_clr;
   logic              w_wd_en;
   logic              w_wd_exp;
   logic [WDOG_W-1:0] w_wd_cnt;
   logic              w_accept;
   logic              w_b_fin;

   assign w_in_wait  = is_wait(r_state);
   assign w_iter_inc = r_iter + 1'b1;

   // Count never runs past TIMEOUT even if held in WAIT.
   assign w_wd_clr = en_i & (abort_i | ~w_in_wait);
   assign w_wd_en  = en_i & w_in_wait &
                     (w_wd_cnt < WDOG_W'(TIMEOUT));

   pass_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_wdog (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .i_clr     (w_wd_clr),
      .i_en      (w_wd_en),
      .o_count   (w_wd_cnt),
      .o_expired (w_wd_exp)
   );

   assign w_accept = (r_state == S_IDLE) & start_i & ~abort_i;
   assign w_b_fin  = (r_state == S_B_WAIT) & b_done_i & ~abort_i;

   // Done is tested before expiry so a late done still wins.
   always_comb begin
      w_nxt = r_state;
      if (abort_i) begin
         w_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start_i)
                  w_nxt = (iters_i != '0) ? S_F0_GO : S_FIN;
            end
            S_F0_GO: w_nxt = S_F0_WAIT;
            S_F0_WAIT: begin
               if (f0_done_i)     w_nxt = S_F1_GO;
               else if (w_wd_exp) w_nxt = S_ERR;
            end
            S_F1_GO: w_nxt = S_F1_WAIT;
            S_F1_WAIT: begin
               if (f1_done_i)     w_nxt = S_B_GO;
               else if (w_wd_exp) w_nxt = S_ERR;
            end
            S_B_GO: w_nxt = S_B_WAIT;
            S_B_WAIT: begin
               if (b_done_i)
                  w_nxt = (w_iter_inc < r_iters) ? S_F0_GO : S_FIN;
               else if (w_wd_exp)
                  w_nxt = S_ERR;
            end
            S_FIN:   w_nxt = S_IDLE;
            S_ERR:   w_nxt = S_ERR;
            default: w_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state    <= S_IDLE;
         r_iters    <= '0;
         r_iter     <= '0;
         f0_start_o <= 1'b0;
         f1_start_o <= 1'b0;
         b_start_o  <= 1'b0;
         busy_o     <= 1'b0;
         done_o     <= 1'b0;
         err_o      <= 1'b0;
         pass_o     <= 2'd0;
      end else if (en_i) begin
         r_state    <= w_nxt;
         f0_start_o <= (w_nxt == S_F0_GO);
         f1_start_o <= (w_nxt == S_F1_GO);
         b_start_o  <= (w_nxt == S_B_GO);
         done_o     <= (w_nxt == S_FIN);
         err_o      <= (w_nxt == S_ERR);
         busy_o     <= (w_nxt != S_IDLE) && (w_nxt != S_ERR);
         pass_o     <= pass_of(w_nxt);
         if (w_accept) begin
            r_iters <= iters_i;
            r_iter  <= '0;
         end else if (w_b_fin) begin
            r_iter  <= w_iter_inc;
         end
      end
   end

   assign iter_o = r_iter;

endmodule

// File: tb/tb_train_pass_sched.sv
// Scenario bench for train_pass_sched: pulse order is checked
// against a scoreboard queue filled when a run is launched.
module tb_train_pass_sched;

   localparam int ITER_W = 4;

   logic              clk = 1'b0;
   logic              rst_i = 1'b0;
   logic              en_i = 1'b0;
   logic              start_i = 1'b0;
   logic              abort_i = 1'b0;
   logic [ITER_W-1:0] iters_i = '0;
   logic              f0_done_i = 1'b0;
   logic              f1_done_i = 1'b0;
   logic              b_done_i = 1'b0;
   logic              f0_start_o, f1_start_o, b_start_o;
   logic              busy_o, done_o, err_o;
   logic [1:0]        pass_o;
   logic [ITER_W-1:0] iter_o;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_q[$];

   always #5 clk = ~clk;

   train_pass_sched #(
      .ITER_W  (ITER_W),
      .TIMEOUT (10)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst_i),
      .en_i       (en_i),
      .start_i    (start_i),
      .abort_i    (abort_i),
      .iters_i    (iters_i),
      .f0_done_i  (f0_done_i),
      .f1_done_i  (f1_done_i),
      .b_done_i   (b_done_i),
      .f0_start_o (f0_start_o),
      .f1_start_o (f1_start_o),
      .b_start_o  (b_start_o),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .err_o      (err_o),
      .pass_o     (pass_o),
      .iter_o     (iter_o)
   );

   function automatic logic cur_go();
      return f0_start_o | f1_start_o | b_start_o;
   endfunction

   function automatic int pulse_code();
      if (f0_start_o) return 1;
      if (f1_start_o) return 2;
      if (b_start_o)  return 3;
      if (done_o)     return 4;
      return 0;
   endfunction

   task automatic launch(input logic [ITER_W-1:0] n);
      start_i = 1'b1;
      iters_i = n;
      @(negedge clk);
      start_i = 1'b0;
   endtask

   task automatic do_abort();
      abort_i = 1'b1;
      @(negedge clk);
      abort_i = 1'b0;
   endtask

   // Plays the datapath: answers whichever WAIT is active.
   task automatic advance_to(input logic [1:0] p, input logic go,
                             output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 60; c++) begin
         f0_done_i = 1'b0;
         f1_done_i = 1'b0;
         b_done_i  = 1'b0;
         if (pass_o == p && cur_go() == go) begin
            ok = 1'b1;
            return;
         end
         if (!cur_go()) begin
            case (pass_o)
               2'd1:    f0_done_i = 1'b1;
               2'd2:    f1_done_i = 1'b1;
               2'd3:    b_done_i  = 1'b1;
               default: ;
            endcase
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_tests++;
      if ({f0_start_o, f1_start_o, b_start_o, busy_o, done_o,
           err_o, pass_o, iter_o} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs got=%b%b%b%b%b%b %0d %0d want all 0",
                  f0_start_o, f1_start_o, b_start_o, busy_o,
                  done_o, err_o, pass_o, iter_o);
      end
      rst_i = 1'b1;
      en_i  = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_sequence(input logic [ITER_W-1:0] n,
                                input int lat);
      int code, got, dly, pend;
      exp_q.delete();
      for (int i = 0; i < int'(n); i++) begin
         exp_q.push_back(1);
         exp_q.push_back(2);
         exp_q.push_back(3);
      end
      exp_q.push_back(4);
      dly  = 0;
      pend = 0;
      launch(n);
      for (int c = 0; c < 300 && exp_q.size() > 0; c++) begin
         f0_done_i = 1'b0;
         f1_done_i = 1'b0;
         b_done_i  = 1'b0;
         if (dly > 0) begin
            dly--;
            if (dly == 0) begin
               case (pend)
                  1:       f0_done_i = 1'b1;
                  2:       f1_done_i = 1'b1;
                  default: b_done_i  = 1'b1;
               endcase
            end
         end
         code = pulse_code();
         if (code != 0) begin
            got = exp_q.pop_front();
            n_tests++;
            if (code !== got) begin
               n_fail++;
               $display("FAIL seq_pulse_order got=%0d want=%0d",
                        code, got);
            end
            if (code < 4) begin
               dly  = lat;
               pend = code;
            end
         end
         @(negedge clk);
      end
      f0_done_i = 1'b0;
      f1_done_i = 1'b0;
      b_done_i  = 1'b0;
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL seq_timeout pending=%0d want=0", exp_q.size());
      end
      for (int c = 0; c < 4; c++) begin
         n_tests++;
         if (pulse_code() != 0) begin
            n_fail++;
            $display("FAIL seq_extra_pulse got=%0d want=0",
                     pulse_code());
         end
         @(negedge clk);
      end
      n_tests++;
      if (iter_o !== n || busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL seq_final iter=%0d busy=%b want iter=%0d busy=0",
                  iter_o, busy_o, n);
      end
   endtask

   task automatic test_two_iters();
      test_sequence(4'd2, 3);
   endtask

   task automatic test_zero_iters();
      launch(4'd0);
      n_tests++;
      if (done_o !== 1'b1 || cur_go() !== 1'b0 ||
          iter_o !== '0) begin
         n_fail++;
         $display("FAIL zero_done done=%b go=%b iter=%0d want 1 0 0",
                  done_o, cur_go(), iter_o);
      end
      @(negedge clk);
      n_tests++;
      if (done_o !== 1'b0 || busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_idle done=%b busy=%b want 0 0",
                  done_o, busy_o);
      end
   endtask

   task automatic test_ignored();
      bit ok;
      launch(4'd1);
      advance_to(2'd1, 1'b0, ok);
      b_done_i  = 1'b1;
      f1_done_i = 1'b1;
      @(negedge clk);
      b_done_i  = 1'b0;
      f1_done_i = 1'b0;
      n_tests++;
      if (!ok || pass_o !== 2'd1 || cur_go() !== 1'b0) begin
         n_fail++;
         $display("FAIL ign_f0wait ok=%b pass=%0d go=%b want 1 1 0",
                  ok, pass_o, cur_go());
      end
      advance_to(2'd3, 1'b0, ok);
      f1_done_i = 1'b1;
      f0_done_i = 1'b1;
      @(negedge clk);
      f1_done_i = 1'b0;
      f0_done_i = 1'b0;
      n_tests++;
      if (!ok || pass_o !== 2'd3 || cur_go() !== 1'b0 ||
          done_o !== 1'b0) begin
         n_fail++;
         $display("FAIL ign_bwait ok=%b pass=%0d go=%b done=%b want 1 3 0 0",
                  ok, pass_o, cur_go(), done_o);
      end
      b_done_i = 1'b1;
      @(negedge clk);
      b_done_i = 1'b0;
      n_tests++;
      if (done_o !== 1'b1 || iter_o !== 4'd1) begin
         n_fail++;
         $display("FAIL ign_fin done=%b iter=%0d want 1 1",
                  done_o, iter_o);
      end
      @(negedge clk);
   endtask

   task automatic test_timeout();
      bit ok;
      int n;
      launch(4'd2);
      advance_to(2'd3, 1'b0, ok);
      advance_to(2'd2, 1'b0, ok);
      n = 0;
      for (int c = 0; c < 30 && !err_o; c++) begin
         if (pass_o == 2'd2) n++;
         @(negedge clk);
      end
      n_tests++;
      if (!ok || n != 10 || err_o !== 1'b1) begin
         n_fail++;
         $display("FAIL to_cycles ok=%b waits=%0d err=%b want 1 10 1",
                  ok, n, err_o);
      end
      n_tests++;
      if (busy_o !== 1'b0 || pass_o !== 2'd0 || iter_o !== 4'd1) begin
         n_fail++;
         $display("FAIL to_outputs busy=%b pass=%0d iter=%0d want 0 0 1",
                  busy_o, pass_o, iter_o);
      end
      launch(4'd3);
      repeat (3) @(negedge clk);
      n_tests++;
      if (err_o !== 1'b1 || cur_go() !== 1'b0) begin
         n_fail++;
         $display("FAIL to_sticky err=%b go=%b want 1 0", err_o, cur_go());
      end
      do_abort();
      n_tests++;
      if (err_o !== 1'b0 || busy_o !== 1'b0 || iter_o !== 4'd1) begin
         n_fail++;
         $display("FAIL to_abort err=%b busy=%b iter=%0d want 0 0 1",
                  err_o, busy_o, iter_o);
      end
   endtask

   task automatic test_done_wins();
      bit ok;
      launch(4'd1);
      advance_to(2'd1, 1'b0, ok);
      repeat (9) @(negedge clk);
      f0_done_i = 1'b1;
      @(negedge clk);
      f0_done_i = 1'b0;
      n_tests++;
      if (!ok || f1_start_o !== 1'b1 || err_o !== 1'b0) begin
         n_fail++;
         $display("FAIL done_wins ok=%b f1_start=%b err=%b want 1 1 0",
                  ok, f1_start_o, err_o);
      end
      do_abort();
   endtask

   task automatic test_enable();
      bit ok;
      bit bad;
      int n;
      launch(4'd1);
      advance_to(2'd2, 1'b1, ok);
      en_i = 1'b0;
      bad  = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (f1_start_o !== 1'b1 || pass_o !== 2'd2) bad = 1'b1;
      end
      n_tests++;
      if (!ok || bad) begin
         n_fail++;
         $display("FAIL en_go_hold ok=%b f1_start=%b want 1 1",
                  ok, f1_start_o);
      end
      en_i = 1'b1;
      @(negedge clk);
      n_tests++;
      if (f1_start_o !== 1'b0 || pass_o !== 2'd2) begin
         n_fail++;
         $display("FAIL en_go_once f1_start=%b pass=%0d want 0 2",
                  f1_start_o, pass_o);
      end
      repeat (4) @(negedge clk);
      en_i = 1'b0;
      bad  = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (err_o !== 1'b0 || pass_o !== 2'd2) bad = 1'b1;
      end
      n_tests++;
      if (bad) begin
         n_fail++;
         $display("FAIL en_wdog_frozen err=%b pass=%0d want 0 2",
                  err_o, pass_o);
      end
      en_i = 1'b1;
      n = 0;
      for (int c = 0; c < 30 && !err_o; c++) begin
         n++;
         @(negedge clk);
      end
      n_tests++;
      if (n != 6 || err_o !== 1'b1) begin
         n_fail++;
         $display("FAIL en_wdog_resume waits=%0d err=%b want 6 1",
                  n, err_o);
      end
      do_abort();
   endtask

   task automatic test_reset_restart();
      bit ok;
      bit bad;
      launch(4'd2);
      advance_to(2'd3, 1'b0, ok);
      rst_i = 1'b0;
      #1;
      n_tests++;
      if (!ok || {f0_start_o, f1_start_o, b_start_o, busy_o, done_o,
                  err_o, pass_o, iter_o} !== '0) begin
         n_fail++;
         $display("FAIL rst_async ok=%b busy=%b pass=%0d iter=%0d want 1 0 0 0",
                  ok, busy_o, pass_o, iter_o);
      end
      @(negedge clk);
      rst_i = 1'b1;
      bad   = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (pulse_code() != 0 || busy_o !== 1'b0) bad = 1'b1;
      end
      n_tests++;
      if (bad) begin
         n_fail++;
         $display("FAIL rst_release code=%0d busy=%b want 0 0",
                  pulse_code(), busy_o);
      end
      test_sequence(4'd2, 1);
   endtask

   initial begin
      test_reset();
      test_two_iters();
      test_zero_iters();
      test_ignored();
      test_timeout();
      test_done_wins();
      test_enable();
      test_reset_restart();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/train_pass_sched.md
TRAIN_PASS_SCHED -- requirements
Module: train_pass_sched

Interface
REQ-001 SHALL have parameter ITER_W, default 4, width of iteration count.
REQ-002 SHALL have parameter TIMEOUT, default 255, max cycles waiting for any pass done (1..255).
REQ-003 SHALL have port clk_i  input  1  clock, all state on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en_i  input  1  global enable; low freezes FSM, counters and outputs.
REQ-006 SHALL have port start_i  input  1  begin training run; sampled only in IDLE.
REQ-007 SHALL have port abort_i  input  1  return to IDLE from any state.
REQ-008 SHALL have port iters_i  input  ITER_W  number of f0->f1->b iterations; sampled on accepted start.
REQ-009 SHALL have ports f0_done_i, f1_done_i, b_done_i  input  1 each  pass-complete pulses from datapath.
REQ-010 SHALL have ports f0_start_o, f1_start_o, b_start_o  output  1 each  single-cycle pass launch pulses.
REQ-011 SHALL have ports busy_o  output  1  run in progress; done_o  output  1  run-complete pulse; err_o  output  1  watchdog error, sticky.
REQ-012 SHALL have ports pass_o  output  2  current pass (0 none, 1 f0, 2 f1, 3 b); iter_o  output  ITER_W  completed iterations.

Function
REQ-013 FSM states SHALL be IDLE, F0_GO, F0_WAIT, F1_GO, F1_WAIT, B_GO, B_WAIT, FIN, ERR.
REQ-014 All outputs SHALL be registered or decoded solely from registered state (Moore); no input-to-output path.
REQ-015 IDLE: start_i=1 with iters_i>0 -> F0_GO next edge; start_i=1 with iters_i=0 -> FIN; latch iters_i, clear iter count.
REQ-016 Each xx_GO state SHALL last exactly one enabled cycle, asserting matching xx_start_o, then go to xx_WAIT.
REQ-017 F0_WAIT on f0_done_i -> F1_GO; F1_WAIT on f1_done_i -> B_GO; B_WAIT on b_done_i -> increment iter count, then F0_GO if count < latched iters, else FIN.
REQ-018 Done inputs SHALL be ignored outside their own WAIT state; wrong-pass done SHALL be ignored.
REQ-019 FIN SHALL last one cycle asserting done_o, then IDLE; iter_o holds final count until next accepted start.
REQ-020 Watchdog counter SHALL clear on entering any WAIT state and increment each enabled WAIT cycle; reaching TIMEOUT without done -> ERR.
REQ-021 Done arriving in the same cycle watchdog reaches TIMEOUT SHALL win (normal transition, no error).
REQ-022 ERR SHALL assert err_o and hold until abort_i or reset; start_i ignored in ERR.
REQ-023 abort_i SHALL override all transitions, including done and timeout, -> IDLE next edge, clearing watchdog; iter_o retained; err_o cleared.
REQ-024 en_i=0 SHALL hold state, counters and all outputs; a GO pulse in progress SHALL stay asserted and not count as issued until an enabled cycle.
REQ-025 busy_o SHALL be 1 in all states except IDLE and ERR; pass_o SHALL reflect GO/WAIT pass, 0 otherwise.
REQ-026 Iteration counter SHALL be ITER_W bits and never wrap, since terminal compare precedes overflow.

Reset
REQ-027 rst_i low SHALL force IDLE, watchdog 0, iter count 0, latched iters 0, all outputs 0, asynchronously.
REQ-028 Reset mid-pass SHALL not emit any start or done pulse on release.

Structure
REQ-029 State encoding and pass_o codes SHALL live in shared package train_pkg.
REQ-030 Watchdog SHALL be sub-module pass_watchdog (clear, enable, count, expired), parameterised by TIMEOUT.

Verification
REQ-031 iters_i=2, each done 3 cycles after start -> pulse order f0,f1,b,f0,f1,b; one done_o; iter_o=2.
REQ-032 iters_i=0 start -> done_o one cycle later, no start pulses, iter_o=0.
REQ-033 TIMEOUT=10, no f1_done_i -> err_o on the 10th F1_WAIT cycle, stays high; abort_i -> IDLE, err_o=0.
REQ-034 b_done_i in F0_WAIT and f1_done_i in B_WAIT -> ignored, states unchanged.
REQ-035 en_i low 5 cycles during F1_GO -> f1_start_o stays high, one effective pulse; watchdog frozen in WAIT.
REQ-036 rst_i low in B_WAIT of iteration 1 -> all outputs 0, IDLE; new start runs full sequence.
